// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: instruction-memory port, decode-side valid/ready queue head,
// and the branch/jump redirect request.
interface instr_fetch_ctrl_if;
  logic [63:0] inst_addr;
  logic [31:0] inst_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output inst_addr, out_valid, out_instr, out_pc,
    input  inst_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_addr, out_valid, out_instr, out_pc,
    output inst_data, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from a combinational instruction
// memory and buffers words in a 2-entry queue consumed by decode.
module instr_fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] MEM_BYTES = 64'd148
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               done,
  instr_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic        done_q, done_d;

  logic        pop, push, redir, start_ok;
  logic [63:0] pc_inc;
  entry_t      fetched;

  // Next-state: queue push/pop, PC advance, FSM, then redirect and start
  // overrides (start has the final word so it beats a redirect in DONE).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    tail_d   = tail_q;
    done_d   = done_q;

    pop      = (cnt_q != 2'd0) && bus.out_ready;
    push     = (state_q == S_RUN) && ((cnt_q < 2'd2) || pop);
    pc_inc   = pc_q + 64'd4;
    fetched.instr = bus.inst_data;
    fetched.pc    = pc_q;
    redir    = bus.redirect_valid && (state_q != S_IDLE);
    start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Head is always entry 0; tail only meaningful when count==2.
    if (pop && push) begin
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = fetched;
      end else begin
        head_d = fetched;
      end
    end else if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) head_d = fetched;
      else               tail_d = fetched;
      cnt_d = cnt_q + 2'd1;
    end

    case (state_q)
      S_RUN: begin
        if (push) begin
          pc_d = pc_inc;
          if (pc_inc >= MEM_BYTES) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (cnt_d == 2'd0) state_d = S_DONE;
      default: ;
    endcase

    // Redirect flushes whatever is left after this cycle's pop and drops
    // the in-flight fetch, so nothing stale follows the redirect edge.
    if (redir) begin
      cnt_d   = 2'd0;
      pc_d    = bus.redirect_pc & ~64'h3;
      state_d = (pc_d < MEM_BYTES) ? S_RUN : S_DRAIN;
    end

    if (start_ok) begin
      state_d = S_RUN;
      pc_d    = RESET_PC;
      cnt_d   = 2'd0;
    end

    done_d = (state_d == S_DONE);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
    end
  end

  assign bus.inst_addr = pc_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_instr = head_q.instr;
  assign bus.out_pc    = head_q.pc;
  assign done          = done_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a small combinational program ROM.
module tb_instr_fetch_ctrl;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic done;
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(.RESET_PC(64'h0), .MEM_BYTES(64'd148)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Program image: known words at 0x0, 0x28, 0x90; address-tagged filler elsewhere.
  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00600593;
      64'h28:  return 32'hFE0006E3;
      64'h90:  return 32'hFC000CE3;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always_comb bus.inst_data = imem(bus.inst_addr);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    start = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  // Leaves the bench at the negedge of cycle 1 (start sampled at edge 0).
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.inst_addr !== 64'h0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 ||
        bus.out_pc !== 64'h0 || done !== 1'b0)
      $display("FAIL reset_vals addr=%h v=%b instr=%h pc=%h done=%b want all 0",
               bus.inst_addr, bus.out_valid, bus.out_instr, bus.out_pc, done);
    else n_pass++;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_redirect_idle();
    bus.redirect_valid = 1; bus.redirect_pc = 64'h40;
    tick(); tick();
    bus.redirect_valid = 0;
    tick();
    n_checks++;
    if (bus.inst_addr !== 64'h0 || bus.out_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_redirect addr=%h v=%b done=%b want 0/0/0", bus.inst_addr, bus.out_valid, done);
    else n_pass++;
  endtask

  task automatic test_full_program();
    logic [63:0] epc;
    bus.out_ready = 1;
    do_start();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.inst_addr !== 64'h0)
      $display("FAIL fp_cycle1 v=%b addr=%h want 0/0", bus.out_valid, bus.inst_addr);
    else n_pass++;
    tick();
    for (int i = 0; i < 37; i++) begin
      epc = 64'(4 * i);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== epc || bus.out_instr !== imem(epc) || done !== 1'b0)
        $display("FAIL fp_instr%0d v=%b pc=%h instr=%h done=%b want 1/%h/%h/0",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, done, epc, imem(epc));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL fp_done done=%b v=%b want 1/0", done, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_redirect_after_done();
    bus.out_ready = 1;
    bus.redirect_valid = 1; bus.redirect_pc = 64'h90;
    tick();
    bus.redirect_valid = 0;
    n_checks++;
    if (bus.inst_addr !== 64'h90 || done !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL rd_addr addr=%h done=%b v=%b want 90/0/0", bus.inst_addr, done, bus.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h90 || bus.out_instr !== 32'hFC000CE3)
      $display("FAIL rd_head v=%b pc=%h instr=%h want 1/90/fc000ce3", bus.out_valid, bus.out_pc, bus.out_instr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL rd_done v=%b done=%b want 0/1", bus.out_valid, done);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL rd_once v=%b done=%b want 0/1", bus.out_valid, done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.out_ready = 0;
    do_start();
    repeat (4) tick();
    n_checks++;
    if (bus.inst_addr !== 64'h8 || bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0)
      $display("FAIL bp_hold addr=%h v=%b pc=%h want 8/1/0", bus.inst_addr, bus.out_valid, bus.out_pc);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.inst_addr !== 64'h8 || bus.out_pc !== 64'h0)
      $display("FAIL bp_hold2 addr=%h pc=%h want 8/0", bus.inst_addr, bus.out_pc);
    else n_pass++;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i) || bus.out_instr !== imem(64'(4 * i)))
        $display("FAIL bp_seq%0d v=%b pc=%h want 1/%h", i, bus.out_valid, bus.out_pc, 64'(4 * i));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    bus.out_ready = 1;
    do_start();
    repeat (5) tick();
    n_checks++;
    if (bus.out_pc !== 64'h10 || bus.out_valid !== 1'b1)
      $display("FAIL redir_pre pc=%h v=%b want 10/1", bus.out_pc, bus.out_valid);
    else n_pass++;
    bus.redirect_valid = 1; bus.redirect_pc = 64'h2B;
    tick();
    bus.redirect_valid = 0;
    n_checks++;
    if (bus.inst_addr !== 64'h28 || bus.out_valid !== 1'b0)
      $display("FAIL redir_flush addr=%h v=%b want 28/0", bus.inst_addr, bus.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h28 || bus.out_instr !== 32'hFE0006E3)
      $display("FAIL redir_head v=%b pc=%h instr=%h want 1/28/fe0006e3", bus.out_valid, bus.out_pc, bus.out_instr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_pc !== 64'h2C)
      $display("FAIL redir_next pc=%h want 2c", bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_start_in_run();
    apply_reset();
    bus.out_ready = 1;
    do_start();
    tick(); tick();
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (bus.out_pc !== 64'h8 || bus.inst_addr !== 64'hC)
      $display("FAIL start_in_run pc=%h addr=%h want 8/c", bus.out_pc, bus.inst_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    bus.out_ready = 1;
    do_start();
    repeat (4) tick();
    n_checks++;
    if (bus.out_pc !== 64'hC)
      $display("FAIL mr_pre pc=%h want c", bus.out_pc);
    else n_pass++;
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (bus.inst_addr !== 64'h0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 ||
        bus.out_pc !== 64'h0 || done !== 1'b0)
      $display("FAIL mr_async addr=%h v=%b instr=%h pc=%h done=%b want all 0",
               bus.inst_addr, bus.out_valid, bus.out_instr, bus.out_pc, done);
    else n_pass++;
    tick();
    reset_n = 1;
    repeat (3) tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.inst_addr !== 64'h0)
      $display("FAIL mr_idle v=%b addr=%h want 0/0", bus.out_valid, bus.inst_addr);
    else n_pass++;
    do_start();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h00600593)
      $display("FAIL mr_restart v=%b pc=%h instr=%h want 1/0/00600593", bus.out_valid, bus.out_pc, bus.out_instr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_pc !== 64'h4)
      $display("FAIL mr_restart2 pc=%h want 4", bus.out_pc);
    else n_pass++;
  endtask

  initial begin
    bus.out_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    test_reset();
    test_redirect_idle();
    test_full_program();
    test_redirect_after_done();
    test_backpressure();
    test_redirect();
    test_start_in_run();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
